// File: rtl/id_fetch_sink.sv
// ID-side endpoint of the IF<->ID fetch interface: IF/ID register, redirect decode and wrong-path squash.
// Optional redirect/squash counters are enabled by defining REDIRECT_COUNT_EN.
module id_fetch_sink #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
`ifdef REDIRECT_COUNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] pc2id,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [31:0] branch_adder,
    output logic [25:0] jmp_addr,
    output logic [1:0]  Jmp,
    output logic        and_z_b,
    output logic [31:0] address_on_reg
`ifdef REDIRECT_COUNT_EN
    ,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] squash_cnt
`endif
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_e;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [1:0] JMP_SEQ = 2'b00;
    localparam logic [1:0] JMP_IMM = 2'b01;
    localparam logic [1:0] JMP_REG = 2'b10;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic        decode_en;
    logic        redirect;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm16;

    assign opcode = instr_q[31:26];
    assign funct  = instr_q[5:0];
    assign imm16  = instr_q[15:0];

    // A bubble, a stalled slot, or a slot being reset this cycle never redirects.
    assign decode_en = valid_q && !stall && rst;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        Jmp     = JMP_SEQ;
        and_z_b = 1'b0;
        if (decode_en) begin
            unique case (opcode)
                OP_BEQ:         and_z_b = (rs_data == rt_data);
                OP_BNE:         and_z_b = (rs_data != rt_data);
                OP_J, OP_JAL:   Jmp = JMP_IMM;
                OP_SPECIAL: begin
                    if (funct == FN_JR || funct == FN_JALR) begin
                        Jmp = JMP_REG;
                    end
                end
                default: ;
            endcase
        end
    end

    assign redirect = and_z_b | (Jmp != JMP_SEQ);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush) begin
            state_d = ST_SQUASH;
            valid_d = 1'b0;
            instr_d = instruction;
            pc4_d   = pc2id;
        end else if (!stall) begin
            instr_d = instruction;
            pc4_d   = pc2id;
            unique case (state_q)
                ST_RUN: begin
                    // The instruction arriving with a taken redirect is wrong-path: keep it as a bubble.
                    if (redirect) begin
                        state_d = ST_SQUASH;
                        valid_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                        valid_d = 1'b1;
                    end
                end
                ST_SQUASH: begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                end
                default: begin
                    state_d = ST_SQUASH;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and active-low; only control state needs clearing, but the
        //       instruction register is reset too so a reset bubble decodes as NOP_INSTR.
        if (!rst) begin
            state_q <= ST_SQUASH;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign id_instr       = valid_q ? instr_q : NOP_INSTR;
    assign id_pc4         = pc4_q;
    assign id_valid       = valid_q;
    assign branch_adder   = pc4_q + {{14{imm16[15]}}, imm16, 2'b00};
    assign jmp_addr       = instr_q[25:0];
    assign address_on_reg = rs_data;

`ifdef REDIRECT_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
    logic             squash_load;

    assign squash_load = flush | redirect;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        squash_cnt_d   = squash_cnt_q;
        if (redirect && redirect_cnt_q != CNT_MAX) begin
            redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
        end
        if (squash_load && squash_cnt_q != CNT_MAX) begin
            squash_cnt_d = squash_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            redirect_cnt_q <= '0;
            squash_cnt_q   <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            squash_cnt_q   <= squash_cnt_d;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign squash_cnt   = squash_cnt_q;
`endif

endmodule

// File: tb/tb_id_fetch_sink.sv
// Directed bench for id_fetch_sink; counter checks run only when REDIRECT_COUNT_EN is defined.
module tb_id_fetch_sink;

    localparam logic [31:0] ADDI = 32'h2008_0005;
    localparam logic [31:0] BEQ  = 32'h1000_0003;
    localparam logic [31:0] BNE  = 32'h1400_0002;
    localparam logic [31:0] JI   = 32'h0800_0040;
    localparam logic [31:0] JR   = 32'h0020_0008;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction, pc2id, rs_data, rt_data;
    logic        stall, flush;
    logic [31:0] id_instr, id_pc4, branch_adder, address_on_reg;
    logic        id_valid, and_z_b;
    logic [25:0] jmp_addr;
    logic [1:0]  jmp;
`ifdef REDIRECT_COUNT_EN
    logic [1:0]  redirect_cnt, squash_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef REDIRECT_COUNT_EN
    id_fetch_sink #(.CNT_W(2)) dut (
`else
    id_fetch_sink dut (
`endif
        .clk(clk), .rst(rst), .instruction(instruction), .pc2id(pc2id),
        .stall(stall), .flush(flush), .rs_data(rs_data), .rt_data(rt_data),
        .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid),
        .branch_adder(branch_adder), .jmp_addr(jmp_addr), .Jmp(jmp),
        .and_z_b(and_z_b), .address_on_reg(address_on_reg)
`ifdef REDIRECT_COUNT_EN
        , .redirect_cnt(redirect_cnt), .squash_cnt(squash_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; instruction = ADDI; pc2id = 32'h4; stall = 1'b0; flush = 1'b0;
        rs_data = 32'd0; rt_data = 32'd0;
        tick(); tick();
        check("rst_valid", id_valid, 0);
        check("rst_instr", id_instr, 32'h0);
        check("rst_pc4", id_pc4, 32'h0);
        check("rst_jmp", jmp, 0);
        check("rst_azb", and_z_b, 0);

        // 1: reset release
        rst = 1'b1; #1;
        check("t1_valid0", id_valid, 0);
        tick();
        check("t1_valid1", id_valid, 1);
        check("t1_instr", id_instr, ADDI);
        check("t1_jmp", jmp, 0);
        check("t1_azb", and_z_b, 0);

        // 2: BEQ taken then not taken
        instruction = BEQ; pc2id = 32'h100; rs_data = 32'd7; rt_data = 32'd7;
        tick();
        check("t2_azb_taken", and_z_b, 1);
        check("t2_badd", branch_adder, 32'h10C);
        instruction = ADDI; pc2id = 32'h104;
        tick();
        check("t2_bubble", id_valid, 0);
        check("t2_bubble_instr", id_instr, 32'h0);
        check("t2_bubble_azb", and_z_b, 0);
        instruction = BEQ; pc2id = 32'h108; rt_data = 32'd8;
        tick();
        check("t2_reload", id_valid, 1);
        check("t2_azb_nt", and_z_b, 0);
        check("t2_badd2", branch_adder, 32'h114);
        check("t2_pc4", id_pc4, 32'h108);
        instruction = ADDI; pc2id = 32'h10C;
        tick();
        check("t2_no_bubble", id_valid, 1);
        check("t2_next_instr", id_instr, ADDI);

        // 3: J then JR, one bubble each
        instruction = JI;
        tick();
        check("t3_j_jmp", jmp, 2'b01);
        check("t3_j_addr", jmp_addr, 26'h40);
        check("t3_j_azb", and_z_b, 0);
        instruction = ADDI;
        tick();
        check("t3_j_bubble", id_valid, 0);
        tick();
        check("t3_j_resume", id_valid, 1);
        instruction = JR; rs_data = 32'h2000;
        tick();
        check("t3_jr_jmp", jmp, 2'b10);
        check("t3_jr_target", address_on_reg, 32'h2000);
        instruction = ADDI;
        tick();
        check("t3_jr_bubble", id_valid, 0);
        tick();
        check("t3_jr_resume", id_valid, 1);

        // 4: BNE taken, stalled for 3 cycles
        instruction = BNE; rs_data = 32'd1; rt_data = 32'd2;
        tick();
        stall = 1'b1; instruction = ADDI; #1;
        check("t4_stall_azb", and_z_b, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_hold_valid", id_valid, 1);
            check("t4_hold_instr", id_instr, BNE);
            check("t4_hold_azb", and_z_b, 0);
        end
        stall = 1'b0; #1;
        check("t4_release_azb", and_z_b, 1);
        tick();
        check("t4_bubble", id_valid, 0);
        tick();
        check("t4_resume", id_instr, ADDI);

        // 5: flush beats stall and a taken BEQ
        instruction = BEQ; rs_data = 32'd7; rt_data = 32'd7;
        tick();
        check("t5_azb_pre", and_z_b, 1);
        stall = 1'b1; flush = 1'b1; instruction = ADDI; #1;
        check("t5_azb_stalled", and_z_b, 0);
        tick();
        check("t5_flushed", id_valid, 0);
        stall = 1'b0; flush = 1'b0;
        tick();
        check("t5_resume", id_valid, 1);
        check("t5_instr", id_instr, ADDI);

        // mid-operation reset suppresses a pending redirect
        instruction = BEQ;
        tick();
        check("rst2_azb_pre", and_z_b, 1);
        rst = 1'b0; #1;
        check("rst2_azb_now", and_z_b, 0);
        tick();
        check("rst2_valid", id_valid, 0);
        check("rst2_instr", id_instr, 32'h0);
        check("rst2_pc4", id_pc4, 32'h0);
        check("rst2_azb_next", and_z_b, 0);

`ifdef REDIRECT_COUNT_EN
        // 6: saturating counters, CNT_W=2
        check("t6_rcnt0", redirect_cnt, 0);
        check("t6_scnt0", squash_cnt, 0);
        rst = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_flush_rcnt", redirect_cnt, 0);
        check("t6_flush_scnt", squash_cnt, 1);
        for (int i = 0; i < 5; i++) begin
            instruction = BEQ;
            tick();
            instruction = ADDI;
            tick();
            if (i == 0) begin
                check("t6_rcnt1", redirect_cnt, 1);
                check("t6_scnt2", squash_cnt, 2);
            end
        end
        check("t6_rcnt_sat", redirect_cnt, 3);
        check("t6_scnt_sat", squash_cnt, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
